// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter time-sharing one combinational ALU between two requesters
//
// Purpose:
//   Two requesters share a single combinational ALU. Requester 0 is the
//   execute stage and requester 1 is the branch/address unit. At most one
//   request is granted per cycle. The granted operands drive the ALU. The
//   result is captured into a one-entry response buffer that is tagged with
//   the requester id.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie and
//                           no round-robin pointer exists. When undefined,
//                           ties are broken round-robin.
//
// Ports:
//   clk, rst_n                  rising-edge clock, synchronous active-low reset
//   reqValid0/1, reqReady0/1    request handshake, one per requester
//   reqA0/1, reqB0/1, reqOp0/1  request operands and opcode
//   respValid, respReady        response handshake
//   respId, respData, respErr   buffered response: issuing requester, result,
//                               and unsupported-opcode flag
//   aluInputA/B, aluOpCode      operands driven to the shared ALU
//   aluOut                      result returned by the shared ALU

module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid0,
  output logic              reqReady0,
  input  logic [DATA_W-1:0] reqA0,
  input  logic [DATA_W-1:0] reqB0,
  input  logic [OP_W-1:0]   reqOp0,
  input  logic              reqValid1,
  output logic              reqReady1,
  input  logic [DATA_W-1:0] reqA1,
  input  logic [DATA_W-1:0] reqB1,
  input  logic [OP_W-1:0]   reqOp1,
  output logic              respValid,
  input  logic              respReady,
  output logic              respId,
  output logic [DATA_W-1:0] respData,
  output logic              respErr,
  output logic [DATA_W-1:0] aluInputA,
  output logic [DATA_W-1:0] aluInputB,
  output logic [OP_W-1:0]   aluOpCode,
  input  logic [DATA_W-1:0] aluOut
);

  logic              buf_full;
  logic              buf_id;
  logic [DATA_W-1:0] buf_data;
  logic              buf_err;

  logic              can_accept;
  logic              grant0;
  logic              grant1;
  logic              grant_any;
  logic              sel_err;
  logic [DATA_W-1:0] sel_result;

  // The buffer can take a new result when it is empty, or when it is
  // draining on this same edge. Reset blocks acceptance, so requests
  // presented while rst_n is low are never granted.
  assign can_accept = rst_n && (!buf_full || respReady);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = can_accept && reqValid0;
  assign grant1 = can_accept && reqValid1 && !reqValid0;
`else
  // last_grant == 1 means requester 0 wins the next tie.
  logic last_grant;

  assign grant0 = can_accept && reqValid0 && (!reqValid1 || last_grant);
  assign grant1 = can_accept && reqValid1 && (!reqValid0 || !last_grant);
`endif

  assign grant_any = grant0 || grant1;
  assign reqReady0 = grant0;
  assign reqReady1 = grant1;

  // Drive the ALU from the winner. Idle cycles drive zeros so that the ALU
  // inputs do not toggle with requests that were not granted.
  always_comb begin
    aluInputA = '0;
    aluInputB = '0;
    aluOpCode = '0;
    if (grant0) begin
      aluInputA = reqA0;
      aluInputB = reqB0;
      aluOpCode = reqOp0;
    end else if (grant1) begin
      aluInputA = reqA1;
      aluInputB = reqB1;
      aluOpCode = reqOp1;
    end
  end

  // Opcodes 0-5 and 7 are supported. Opcode 6 and any opcode with a bit set
  // above bit 2 are unsupported. An unsupported request is still consumed,
  // but it reports an error and returns zero instead of the ALU output.
  assign sel_err    = grant_any &&
                      ((aluOpCode > OP_W'(7)) || (aluOpCode == OP_W'(6)));
  assign sel_result = sel_err ? '0 : aluOut;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_id   <= 1'b0;
      buf_data <= '0;
      buf_err  <= 1'b0;
    end else if (grant_any) begin
      // A grant overwrites the buffer, including a buffer draining this cycle.
      buf_full <= 1'b1;
      buf_id   <= grant1;
      buf_data <= sel_result;
      buf_err  <= sel_err;
    end else if (buf_full && respReady) begin
      buf_full <= 1'b0;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // The pointer moves only when a request is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant_any) begin
      last_grant <= grant1;
    end
  end
`endif

  assign respValid = buf_full;
  assign respId    = buf_id;
  assign respData  = buf_data;
  assign respErr   = buf_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed table-driven bench for alu_share_arbiter
//
// Purpose:
//   Drives directed request vectors. Each vector carries hand-computed
//   expected handshake and response values. A small reference ALU lives in
//   the bench. Hand-written sequences cover reset and reset during operation.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN - selects the fixed-priority sequence instead of
//                           the round-robin table.

module tb_alu_share_arbiter;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              reqValid0, reqValid1;
  logic              reqReady0, reqReady1;
  logic [DATA_W-1:0] reqA0, reqB0, reqA1, reqB1;
  logic [OP_W-1:0]   reqOp0, reqOp1;
  logic              respValid, respReady, respId, respErr;
  logic [DATA_W-1:0] respData;
  logic [DATA_W-1:0] aluInputA, aluInputB, aluOut;
  logic [OP_W-1:0]   aluOpCode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid0(reqValid0), .reqReady0(reqReady0),
    .reqA0(reqA0), .reqB0(reqB0), .reqOp0(reqOp0),
    .reqValid1(reqValid1), .reqReady1(reqReady1),
    .reqA1(reqA1), .reqB1(reqB1), .reqOp1(reqOp1),
    .respValid(respValid), .respReady(respReady), .respId(respId),
    .respData(respData), .respErr(respErr),
    .aluInputA(aluInputA), .aluInputB(aluInputB), .aluOpCode(aluOpCode),
    .aluOut(aluOut)
  );

  // Reference ALU. Unsupported opcodes produce a marker value so that the
  // arbiter's zeroing of the result can be observed.
  always_comb begin
    case (aluOpCode)
      4'd0:    aluOut = aluInputA + aluInputB;
      4'd1:    aluOut = aluInputA - aluInputB;
      4'd2:    aluOut = aluInputA & aluInputB;
      4'd3:    aluOut = aluInputA | aluInputB;
      4'd4:    aluOut = aluInputA ^ aluInputB;
      4'd5:    aluOut = aluInputA << aluInputB[4:0];
      4'd7:    aluOut = (aluInputA < aluInputB) ? 32'd1 : 32'd0;
      default: aluOut = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1,
                       input logic rr);
    reqValid0 = v0; reqA0 = a0; reqB0 = b0; reqOp0 = o0;
    reqValid1 = v1; reqA1 = a1; reqB1 = b1; reqOp1 = o1;
    respReady = rr;
  endtask

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, b0;
    logic [3:0]  o0;
    logic [31:0] a1, b1;
    logic [3:0]  o1;
    logic        rr;
    logic        e_rdy0, e_rdy1;
    logic [31:0] e_alu_a;
    logic        e_valid, e_id;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // Contention with respReady=1: grants alternate 0,1,0,1.
    vecs[0]  = '{1,1, 1,2,0, 10,3,1, 1,  1,0, 1,    1,0, 3,0};
    vecs[1]  = '{1,1, 1,2,0, 10,3,1, 1,  0,1, 10,   1,1, 7,0};
    vecs[2]  = '{1,1, 1,2,0, 10,3,1, 1,  1,0, 1,    1,0, 3,0};
    vecs[3]  = '{1,1, 1,2,0, 10,3,1, 1,  0,1, 10,   1,1, 7,0};
    // Unsupported opcode 6 from requester 1.
    vecs[4]  = '{0,1, 0,0,0, 5,5,6,  1,  0,1, 5,    1,1, 0,1};
    // Backpressure for three cycles, then grants resume.
    vecs[5]  = '{1,1, 32'hF0,32'h3C,2, 32'hF0,32'h0F,3, 0,  0,0, 0,  1,1, 0,1};
    vecs[6]  = '{1,1, 32'hF0,32'h3C,2, 32'hF0,32'h0F,3, 0,  0,0, 0,  1,1, 0,1};
    vecs[7]  = '{1,1, 32'hF0,32'h3C,2, 32'hF0,32'h0F,3, 0,  0,0, 0,  1,1, 0,1};
    vecs[8]  = '{1,1, 32'hF0,32'h3C,2, 32'hF0,32'h0F,3, 1,  1,0, 32'hF0, 1,0, 32'h30,0};
    vecs[9]  = '{1,1, 32'hF0,32'h3C,2, 32'hF0,32'h0F,3, 1,  0,1, 32'hF0, 1,1, 32'hFF,0};
    // Idle cycle drains the buffer.
    vecs[10] = '{0,0, 0,0,0, 0,0,0,  1,  0,0, 0,    0,0, 0,0};
    // Empty buffer accepts even when respReady=0.
    vecs[11] = '{1,0, 5,3,4, 0,0,0,  0,  1,0, 5,    1,0, 6,0};
    vecs[12] = '{1,0, 1,4,5, 0,0,0,  0,  0,0, 0,    1,0, 6,0};
    vecs[13] = '{1,0, 1,4,5, 0,0,0,  1,  1,0, 1,    1,0, 16,0};
    // Tie after requester 0 was last granted goes to requester 1.
    vecs[14] = '{1,1, 9,3,7, 3,9,7,  1,  0,1, 3,    1,1, 1,0};
    // Opcode with bit 3 set is unsupported.
    vecs[15] = '{1,0, 1,1,8, 0,0,0,  1,  1,0, 1,    1,0, 0,1};
    vecs[16] = '{0,0, 0,0,0, 0,0,0,  1,  0,0, 0,    0,0, 0,0};
  end

  initial begin
    rst_n = 1'b0;
    drive(1,1, 1,2,0, 10,3,1, 1);

    // Reset is held for two cycles with both requesters asking.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_rdy0", 32'(reqReady0), 0);
      chk("rst_rdy1", 32'(reqReady1), 0);
      @(posedge clk); #1;
      chk("rst_valid", 32'(respValid), 0);
    end
    chk("rst_id", 32'(respId), 0);
    chk("rst_data", respData, 0);
    chk("rst_err", 32'(respErr), 0);

`ifdef ALU_ARB_FIXED_PRIO_EN
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      drive(1,1, 1,2,0, 10,3,1, 1);
      #1;
      chk("fp_rdy0", 32'(reqReady0), 1);
      chk("fp_rdy1", 32'(reqReady1), 0);
      @(posedge clk); #1;
      chk("fp_valid", 32'(respValid), 1);
      chk("fp_id", 32'(respId), 0);
      chk("fp_data", respData, 3);
    end
`else
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].o0,
            vecs[i].a1, vecs[i].b1, vecs[i].o1, vecs[i].rr);
      #1;
      chk($sformatf("v%0d_rdy0", i), 32'(reqReady0), 32'(vecs[i].e_rdy0));
      chk($sformatf("v%0d_rdy1", i), 32'(reqReady1), 32'(vecs[i].e_rdy1));
      chk($sformatf("v%0d_alu_a", i), aluInputA, vecs[i].e_alu_a);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(respValid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_id", i), 32'(respId), 32'(vecs[i].e_id));
        chk($sformatf("v%0d_data", i), respData, vecs[i].e_data);
        chk($sformatf("v%0d_err", i), 32'(respErr), 32'(vecs[i].e_err));
      end
    end

    // Reset during operation. The pending response is discarded and the
    // pointer returns to favouring requester 0.
    @(negedge clk);
    drive(1,0, 2,2,0, 0,0,0, 1);
    @(posedge clk); #1;
    chk("mid_pre_valid", 32'(respValid), 1);
    chk("mid_pre_data", respData, 4);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1,1, 2,2,0, 10,3,1, 1);
    #1;
    chk("mid_rst_rdy0", 32'(reqReady0), 0);
    chk("mid_rst_rdy1", 32'(reqReady1), 0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(respValid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_post_rdy0", 32'(reqReady0), 1);
    chk("mid_post_rdy1", 32'(reqReady1), 0);
    @(posedge clk); #1;
    chk("mid_post_id", 32'(respId), 0);
    chk("mid_post_data", respData, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter that time-shares the single 32-bit combinational ALU between the execute stage (requester 0) and the branch/address unit (requester 1). It accepts operand/opcode requests over valid/ready handshakes, grants at most one per cycle (round-robin), drives the ALU, and registers the result into a one-entry response buffer tagged with the requester id. It sits between the pipeline stages and the ALU instance and replaces direct ALU wiring.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 4, ALU opcode width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- reqValid0 / reqValid1  in  1  request present
- reqReady0 / reqReady1  out  1  request accepted this cycle
- reqA0 / reqA1  in  DATA_W  operand A
- reqB0 / reqB1  in  DATA_W  operand B
- reqOp0 / reqOp1  in  OP_W  ALU opcode
- respValid  out  1  response buffer holds a result
- respReady  in  1  consumer takes response
- respId  out  1  requester that issued the result
- respData  out  DATA_W  result
- respErr  out  1  opcode unsupported
- aluInputA  out  DATA_W  to ALU inputA
- aluInputB  out  DATA_W  to ALU inputB
- aluOpCode  out  OP_W  to ALU aluOpCode
- aluOut  in  DATA_W  from ALU out

## Operation
- State: response buffer (EMPTY / FULL), round-robin pointer lastGrant (1 bit).
- canAccept = (buffer EMPTY) or (respValid and respReady).
- Grant (combinational): none if !canAccept. One requester valid -> grant it. Both valid -> grant the requester != lastGrant.
- reqReadyN = grantN; at most one reqReady high per cycle.
- Granted cycle: aluInputA/B/aluOpCode = granted reqA/B/Op; no grant -> all zero.
- Supported opcodes: 4'b0000-4'b0101, 4'b0111. Others (4'b0110, 4'b1xxx): request still accepted, respErr=1, respData=0, aluOut ignored.
- On grant edge: buffer <= {id, aluOut or 0, err}, state FULL, lastGrant <= id.
- No grant and respValid&respReady: state EMPTY.
- Pointer changes only on an accepted grant.

## Timing
- Reset (rst_n=0 at edge): respValid=0, respId=0, respData=0, respErr=0, lastGrant=1 (requester 0 wins first tie). reqReady and alu* outputs are combinational; zero while buffer EMPTY and no requests.
- Latency: request accepted in cycle N -> respValid=1 with result in cycle N+1.
- Throughput: one op/cycle when consumer holds respReady=1; back-to-back grants alternate under continuous contention.
- Backpressure: respValid=1 and respReady=0 -> response held stable, reqReady0/1=0.
- Simultaneous drain and grant: same edge replaces buffer; respValid stays 1.
- Requester may drop reqValid before reqReady; no request latching inside block.
- Reset mid-operation: pending response discarded, pointer reset; requests active during reset not accepted.
- Path reqValid -> reqReady is combinational; respReady -> reqReady is combinational.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins a tie; lastGrant not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Reset: hold rst_n=0 two cycles with both reqValid=1 -> no reqReady, respValid=0; release -> requester 0 granted first cycle, respId=0 next cycle.
- Single op: reqValid0, A=1, B=2, Op=4'b0000, bench ALU model add -> reqReady0=1 cycle N, respValid=1, respData=3, respId=0, respErr=0 cycle N+1.
- Contention: both valid continuously, respReady=1 -> grants 0,1,0,1; respId sequence matches, one response per cycle.
- Backpressure: respReady=0 for 3 cycles after a response -> response stable, both reqReady=0; respReady=1 -> next grant same cycle, new result following cycle.
- Bad opcode: reqOp1=4'b0110 -> accepted, respErr=1, respData=0, respId=1.
- Macro build with ALU_ARB_FIXED_PRIO_EN: both valid 4 cycles -> requester 0 granted every cycle, requester 1 never.
